// File: rtl/event_blinker.sv
// event_blinker: turns single-cycle event strobes into fixed-length LED blinks.
// Each blink holds the LED lit for N_ON cycles, then dark for at least N_OFF
// cycles. Events arriving while a blink or its off-gap is running are queued
// in a saturating counter, so every accepted event yields one distinct blink.
// Events that find the queue full are dropped and flagged on ovf.

module event_blinker #(
    parameter int CLK_HZ = 50_000_000,
    parameter int ON_MS  = 100,
    parameter int OFF_MS = 100,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    output logic              led_n,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    // Phase lengths in clock cycles, and the timer value of each phase's last cycle.
    localparam logic [31:0] N_ON     = 32'((CLK_HZ / 1000) * ON_MS);
    localparam logic [31:0] N_OFF    = 32'((CLK_HZ / 1000) * OFF_MS);
    localparam logic [31:0] ON_LAST  = N_ON - 32'd1;
    localparam logic [31:0] OFF_LAST = N_OFF - 32'd1;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [31:0]       timer;
    logic [31:0]       timer_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              ovf_nxt;
    logic              queue_req;

    // Next-state, timer and queue decode for the blink sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // through the case statement leaves one unassigned (which would infer a latch).
        state_nxt   = state;
        timer_nxt   = timer;
        pending_nxt = pending;
        ovf_nxt     = 1'b0;
        queue_req   = 1'b0;

        case (state)
            ST_IDLE: begin
                // An event in idle starts its own blink directly; it never queues.
                if (pulse) begin
                    state_nxt = ST_ON;
                    timer_nxt = 32'd0;
                end
            end

            ST_ON: begin
                if (timer == ON_LAST) begin
                    state_nxt = ST_OFF;
                    timer_nxt = 32'd0;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
                queue_req = pulse;
            end

            ST_OFF: begin
                if (timer == OFF_LAST) begin
                    timer_nxt = 32'd0;
                    if (pending != '0) begin
                        // Consume one queued event. A coincident pulse takes
                        // its place in the queue, so the count is unchanged.
                        state_nxt = ST_ON;
                        if (!pulse) begin
                            pending_nxt = pending - 1'b1;
                        end
                    end else if (pulse) begin
                        // Empty queue: the coincident pulse starts the next blink.
                        state_nxt = ST_ON;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer + 32'd1;
                    queue_req = pulse;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = 32'd0;
            end
        endcase

        // Queue an event, or drop it and flag the loss when the queue is full.
        if (queue_req) begin
            if (pending == PEND_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                pending_nxt = pending + 1'b1;
            end
        end
    end

    // State registers; outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= 32'd0;
            pending <= '0;
            ovf     <= 1'b0;
            led_n   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            led_n   <= (state_nxt != ST_ON);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_event_blinker.sv
// Testbench for event_blinker with N_ON = N_OFF = 4 cycles.
// dut_a uses a 3-bit queue, dut_b a 2-bit queue for the overflow case.
// Each vector drives pulse for one cycle and lists the outputs expected
// just after the clock edge that samples it.

module tb_event_blinker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_a = 1'b0;
    logic       pulse_b = 1'b0;
    logic       led_n_a, busy_a, ovf_a;
    logic       led_n_b, busy_b, ovf_b;
    logic [2:0] pending_a;
    logic [1:0] pending_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         sel;      // 0 = dut_a, 1 = dut_b
        bit         pulse;
        bit         exp_led_n;
        bit         exp_busy;
        logic [2:0] exp_pending;
        bit         exp_ovf;
    } vec_t;

    vec_t vec[$];

    event_blinker #(
        .CLK_HZ(4000), .ON_MS(1), .OFF_MS(1), .PEND_W(3)
    ) dut_a (
        .clk    (clk),
        .rst    (rst),
        .pulse  (pulse_a),
        .led_n  (led_n_a),
        .busy   (busy_a),
        .pending(pending_a),
        .ovf    (ovf_a)
    );

    event_blinker #(
        .CLK_HZ(4000), .ON_MS(1), .OFF_MS(1), .PEND_W(2)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .pulse  (pulse_b),
        .led_n  (led_n_b),
        .busy   (busy_b),
        .pending(pending_b),
        .ovf    (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic add(input bit sel, input bit p, input bit led, input bit bsy,
                       input logic [2:0] pnd, input bit ov, input int n);
        vec_t v;
        v.sel = sel; v.pulse = p; v.exp_led_n = led; v.exp_busy = bsy;
        v.exp_pending = pnd; v.exp_ovf = ov;
        for (int i = 0; i < n; i++) vec.push_back(v);
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, " led_n_a"},   32'(led_n_a),   32'd1);
        check({tag, " busy_a"},    32'(busy_a),    32'd0);
        check({tag, " pending_a"}, 32'(pending_a), 32'd0);
        check({tag, " ovf_a"},     32'(ovf_a),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        // 1. single event: 4 cycles lit, 4 dark, then idle
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 3);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 2);
        // 2. queueing: three extra events during the first ON phase
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 2, 0, 1);
        add(0, 1, 0, 1, 3, 0, 1);
        add(0, 0, 1, 1, 3, 0, 4);
        add(0, 0, 0, 1, 2, 0, 4);
        add(0, 0, 1, 1, 2, 0, 4);
        add(0, 0, 0, 1, 1, 0, 4);
        add(0, 0, 1, 1, 1, 0, 4);
        add(0, 0, 0, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 2);
        // 3. overflow on the 2-bit queue: 4th and 5th queued events dropped
        add(1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 0, 1, 1, 0, 1);
        add(1, 1, 0, 1, 2, 0, 1);
        add(1, 1, 0, 1, 3, 0, 1);
        add(1, 1, 1, 1, 3, 1, 1);
        add(1, 1, 1, 1, 3, 1, 1);
        add(1, 0, 1, 1, 3, 0, 2);
        add(1, 0, 0, 1, 2, 0, 4);
        add(1, 0, 1, 1, 2, 0, 4);
        add(1, 0, 0, 1, 1, 0, 4);
        add(1, 0, 1, 1, 1, 0, 4);
        add(1, 0, 0, 1, 0, 0, 4);
        add(1, 0, 1, 1, 0, 0, 4);
        add(1, 0, 1, 0, 0, 0, 2);
        // 4a. pulse on last OFF cycle with empty queue: no idle gap
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 3);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 3);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 2);
        // 4b. pulse on last ON cycle queues one more blink
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 1, 0, 3);
        add(0, 0, 0, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 2);
        // 5. pending=2 plus pulse on last OFF cycle: count unchanged
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 2, 0, 1);
        add(0, 0, 0, 1, 2, 0, 1);
        add(0, 0, 1, 1, 2, 0, 4);
        add(0, 1, 0, 1, 2, 0, 1);
        add(0, 0, 0, 1, 2, 0, 3);
        add(0, 0, 1, 1, 2, 0, 4);
        add(0, 0, 0, 1, 1, 0, 4);
        add(0, 0, 1, 1, 1, 0, 4);
        add(0, 0, 0, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 2);

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        check_a_idle("reset");
        check("reset led_n_b",   32'(led_n_b),   32'd1);
        check("reset busy_b",    32'(busy_b),    32'd0);
        check("reset pending_b", 32'(pending_b), 32'd0);
        check("reset ovf_b",     32'(ovf_b),     32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_a_idle("post-reset");

        // ---------------- table-driven vectors ----------------
        foreach (vec[i]) begin
            pulse_a = vec[i].sel ? 1'b0 : vec[i].pulse;
            pulse_b = vec[i].sel ? vec[i].pulse : 1'b0;
            @(posedge clk);
            #1;
            pulse_a = 1'b0;
            pulse_b = 1'b0;
            if (vec[i].sel) begin
                check($sformatf("vec%0d led_n_b", i),   32'(led_n_b),   32'(vec[i].exp_led_n));
                check($sformatf("vec%0d busy_b", i),    32'(busy_b),    32'(vec[i].exp_busy));
                check($sformatf("vec%0d pending_b", i), 32'(pending_b), 32'(vec[i].exp_pending));
                check($sformatf("vec%0d ovf_b", i),     32'(ovf_b),     32'(vec[i].exp_ovf));
            end else begin
                check($sformatf("vec%0d led_n_a", i),   32'(led_n_a),   32'(vec[i].exp_led_n));
                check($sformatf("vec%0d busy_a", i),    32'(busy_a),    32'(vec[i].exp_busy));
                check($sformatf("vec%0d pending_a", i), 32'(pending_a), 32'(vec[i].exp_pending));
                check($sformatf("vec%0d ovf_a", i),     32'(ovf_a),     32'(vec[i].exp_ovf));
            end
        end

        // ---------------- 6. reset in the middle of a blink ----------------
        for (int i = 0; i < 3; i++) begin
            pulse_a = 1'b1;
            @(posedge clk);
            #1;
        end
        pulse_a = 1'b0;
        check("midblink led_n_a",   32'(led_n_a),   32'd0);
        check("midblink pending_a", 32'(pending_a), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_a_idle("async reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("after reset c%0d led_n_a", i), 32'(led_n_a), 32'd1);
            check($sformatf("after reset c%0d busy_a", i),  32'(busy_a),  32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Output-side counterpart of the button debounce/one-pulse path. It turns single-cycle event pulses (set-mode steps, alarms, rollover ticks) into human-visible LED blinks of fixed on/off duration.
- Events that arrive while a blink is in progress are queued in a saturating counter. Every accepted event therefore produces exactly one distinct blink.
- Drives an active-low LED output on the DE2-115.

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz.
- ON_MS, 100, LED-on time per blink in ms. N_ON = (CLK_HZ/1000)*ON_MS, must be >= 1.
- OFF_MS, 100, minimum LED-off gap after each blink in ms. N_OFF = (CLK_HZ/1000)*OFF_MS, must be >= 1.
- PEND_W, 3, width of the pending-event counter. PEND_MAX = 2**PEND_W - 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pulse  input  1  event strobe; each cycle sampled high is one event.
- led_n  output  1  active-low LED drive; 0 = lit.
- busy  output  1  high while a blink or its off-gap is in progress.
- pending  output  PEND_W  number of queued events not yet started.
- ovf  output  1  one-cycle strobe when an event is dropped because the queue is full.

Behaviour:
Reset (asserted asynchronously, held while rst=1):
- led_n=1, busy=0, pending=0, ovf=0.
- State IDLE, timer counter=0.
- Reset in the middle of a blink forces led_n high immediately and discards all queued events.

State machine (registered; timer is 32-bit):
- IDLE: led_n=1, busy=0. If pulse=1 → ON next cycle with timer=0. pending is not incremented.
- ON: led_n=0, busy=1.
  - Timer counts 0..N_ON-1.
  - On the cycle timer=N_ON-1 → OFF, timer=0.
  - led_n is low for exactly N_ON cycles.
- OFF: led_n=1, busy=1.
  - Timer counts 0..N_OFF-1.
  - On the cycle timer=N_OFF-1:
    - If pending>0, or pulse=1 on that cycle → ON, timer=0.
    - Otherwise → IDLE.
- led_n and busy are registered from the next-state decode. No combinational path exists from pulse to led_n.

Latency:
- pulse sampled high in IDLE at edge k → led_n=0 from edge k (first full low cycle is the one following edge k).
- Blink period for back-to-back events is exactly N_ON+N_OFF cycles. No IDLE cycle is inserted between queued blinks.

Pending counter:
- A pulse in ON or OFF increments pending, except in the simultaneous-consume case below.
- At the OFF→ON transition caused by pending>0, pending decrements by 1.
- Simultaneous pulse and consume at the end of OFF: pending net unchanged.
- pending=0 with pulse on the last OFF cycle: the pulse starts the next blink directly and pending stays 0.
- Pulse while pending=PEND_MAX and no consume that cycle:
  - The event is dropped and pending stays PEND_MAX.
  - ovf=1 for exactly that cycle; otherwise ovf=0.
- pending never wraps.

Input assumptions:
- pulse is synchronous to clk and produced by upstream one-pulse logic. There is no internal synchronizer.
- A pulse held high for multiple cycles counts as multiple events.

Test Plan:
Bench configuration: CLK_HZ=4000, ON_MS=1, OFF_MS=1 (N_ON=4, N_OFF=4), PEND_W=3 unless noted.
1. Single event: one pulse in IDLE at edge k → led_n=0 for edges k..k+3 (4 cycles) and 1 from k+4; busy high for 8 cycles then 0; pending stays 0; ovf never asserts.
2. Queueing: pulse in IDLE, then 3 pulses during the first ON phase → pending reads 1,2,3. Exactly 4 blinks of 4-low/4-high occur back-to-back; pending steps 3→2→1→0 at each OFF→ON transition; busy is continuously high for 32 cycles.
3. Overflow (PEND_W=2): pulse in IDLE, then 5 pulses during ON → pending saturates at 3; ovf pulses one cycle on the 4th and 5th of those pulses; exactly 4 blinks in total.
4. Coincident boundary events:
   - Pulse on the last OFF cycle with pending=0 → next ON starts the following cycle with no IDLE gap; pending stays 0.
   - Pulse on the last ON cycle → pending=1; a second blink follows after OFF.
5. Simultaneous consume: pending=2 and pulse on the last OFF cycle → new blink starts and pending stays 2.
6. Reset mid-operation: assert rst during ON with pending=2 → led_n=1, busy=0, pending=0 immediately (before the next clock edge); after release with no pulses, led_n stays 1 for 40 cycles.
